// File: rtl/conv_display_ctrl_pkg.sv
// Shared constants and types for the binary-to-7-segment display controller.
// Segment constants are active-low, written a..g from left to right.
package conv_display_ctrl_pkg;

  localparam int W_DEF       = 14;
  localparam int NDIG_DEF    = 4;
  localparam int MAX_VAL_DEF = 9999;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_e;

endpackage

// File: rtl/seg7_digito.sv
// Combinational BCD digit to active-low 7-segment pattern decoder.
// Nibbles above 9 light nothing.
module seg7_digito
  import conv_display_ctrl_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [0:6] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/conv_display_ctrl.sv
// Iterative double-dabble converter driving four 7-segment displays.
// One shift per clock; results are held in output registers and blanked by EN.
module conv_display_ctrl
  import conv_display_ctrl_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NDIG    = NDIG_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] X,
  input  logic         EN,
  output logic         busy,
  output logic         done,
  output logic [0:6]   display1,
  output logic [0:6]   display2,
  output logic [0:6]   display3,
  output logic [0:6]   display4
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

  state_e        state_q, state_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic          done_q, done_d;
  logic [0:6]    seg_q [NDIG];
  logic [0:6]    seg_d [NDIG];
  logic [0:6]    digPat [NDIG];
  logic [BW-1:0] adjBcd;

  for (genvar g = 0; g < NDIG; g++) begin : gen_dig
    seg7_digito u_dig (
      .bcd_i(bcd_q[4*g +: 4]),
      .seg_o(digPat[g])
    );
  end

  // Add-3 correction on every nibble before the shift; carry out of the top nibble is dropped.
  always_comb begin
    adjBcd = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adjBcd[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = X;
          bcd_d   = '0;
          cnt_d   = CW'(W);
          sat_d   = (X > MAX_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adjBcd, bin_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        for (int i = 0; i < NDIG; i++) begin
          seg_d[i] = sat_q ? SEG_9 : digPat[i];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        seg_q[i] <= SEG_BLANK;
      end
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  // The done cycle still counts as busy even though the FSM is already back in IDLE.
  assign busy = (state_q != IDLE) || done_q;
  assign done = done_q;

  assign display1 = EN ? seg_q[0] : SEG_BLANK;
  assign display2 = EN ? seg_q[1] : SEG_BLANK;
  assign display3 = EN ? seg_q[2] : SEG_BLANK;
  assign display4 = EN ? seg_q[3] : SEG_BLANK;

endmodule

// File: tb/tb_conv_display_ctrl.sv
// Directed self-checking bench for conv_display_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_conv_display_ctrl;

  localparam logic [27:0] ALL_BLANK = {4{7'b1111111}};
  localparam logic [27:0] ALL_NINE  = {4{7'b0000100}};
  localparam logic [27:0] ALL_ZERO  = {4{7'b0000001}};

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] X;
  logic        EN;
  logic        busy;
  logic        done;
  logic [0:6]  display1, display2, display3, display4;

  int checks = 0;
  int errors = 0;

  conv_display_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .X       (X),
    .EN      (EN),
    .busy    (busy),
    .done    (done),
    .display1(display1),
    .display2(display2),
    .display3(display3),
    .display4(display4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] disp();
    return {display4, display3, display2, display1};
  endfunction

  // Pulse start for one cycle and count falling edges until done (bounded).
  task automatic run_conv(input logic [13:0] x, output int cycles);
    @(negedge clk);
    X = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; X = '0; EN = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (disp() !== ALL_BLANK) begin
      errors++; $display("[TB] FAIL reset_disp: got %h expected %h", disp(), ALL_BLANK);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
  endtask

  task automatic test_basic();
    int c;
    @(negedge clk);
    X = 14'd1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_busy_rise: got %b expected 1", busy);
    end
    c = 1;
    while (done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c !== 16) begin
      errors++; $display("[TB] FAIL basic_latency: got %0d expected 16", c);
    end
    checks++;
    if (disp() !== {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}) begin
      errors++; $display("[TB] FAIL basic_1234: got %h expected %h", disp(),
                         {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
    end
  endtask

  task automatic test_boundaries();
    logic [13:0] vals [4];
    logic [27:0] exps [4];
    int c;
    vals[0] = 14'd0;     exps[0] = ALL_ZERO;
    vals[1] = 14'd9999;  exps[1] = ALL_NINE;
    vals[2] = 14'd10000; exps[2] = ALL_NINE;
    vals[3] = 14'd16383; exps[3] = ALL_NINE;
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], c);
      checks++;
      if (c !== 16) begin
        errors++; $display("[TB] FAIL bound_latency_%0d: got %0d expected 16", vals[i], c);
      end
      checks++;
      if (disp() !== exps[i]) begin
        errors++; $display("[TB] FAIL bound_disp_%0d: got %h expected %h", vals[i], disp(), exps[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int doneCount = 0;
    int doneCycle = 0;
    logic busy16 = 1'b0;
    logic busy17 = 1'b1;
    @(negedge clk);
    X = 14'd56; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        doneCount++;
        doneCycle = c;
      end
      if (c == 16) busy16 = busy;
      if (c == 17) busy17 = busy;
      if (c == 5) begin
        start = 1'b1; X = 14'd78;
      end else if (c == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (doneCount !== 1) begin
      errors++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCount);
    end
    checks++;
    if (doneCycle !== 16) begin
      errors++; $display("[TB] FAIL ignore_done_cycle: got %0d expected 16", doneCycle);
    end
    checks++;
    if (disp() !== {7'b0000001, 7'b0000001, 7'b0100100, 7'b0100000}) begin
      errors++; $display("[TB] FAIL ignore_disp_0056: got %h expected %h", disp(),
                         {7'b0000001, 7'b0000001, 7'b0100100, 7'b0100000});
    end
    checks++;
    if (busy16 !== 1'b1 || busy17 !== 1'b0) begin
      errors++; $display("[TB] FAIL ignore_busy_fall: got %b%b expected 10", busy16, busy17);
    end
  endtask

  task automatic test_back_to_back();
    int doneCount = 0;
    int firstDone = 0;
    int secondDone = 0;
    @(negedge clk);
    X = 14'd100; start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 50; c++) begin
      if (done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) firstDone = c;
        if (doneCount == 2) secondDone = c;
      end
      if (c == 20) start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (doneCount !== 2) begin
      errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", doneCount);
    end
    checks++;
    if (secondDone - firstDone !== 16) begin
      errors++; $display("[TB] FAIL b2b_period: got %0d expected 16", secondDone - firstDone);
    end
    checks++;
    if (disp() !== {7'b0000001, 7'b1001111, 7'b0000001, 7'b0000001}) begin
      errors++; $display("[TB] FAIL b2b_disp_0100: got %h expected %h", disp(),
                         {7'b0000001, 7'b1001111, 7'b0000001, 7'b0000001});
    end
  endtask

  task automatic test_enable();
    int visible = 0;
    int dones = 0;
    @(negedge clk);
    EN = 1'b0; X = 14'd4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (disp() !== ALL_BLANK) visible++;
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (visible !== 0) begin
      errors++; $display("[TB] FAIL enable_blank: got %0d unblanked cycles expected 0", visible);
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("[TB] FAIL enable_done: got %0d expected 1", dones);
    end
    EN = 1'b1;
    #1;
    checks++;
    if (disp() !== {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111}) begin
      errors++; $display("[TB] FAIL enable_show_4321: got %h expected %h", disp(),
                         {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111});
    end
  endtask

  task automatic test_reset_abort();
    int c;
    int dones = 0;
    run_conv(14'd777, c);
    checks++;
    if (disp() !== {7'b0000001, 7'b0001111, 7'b0001111, 7'b0001111}) begin
      errors++; $display("[TB] FAIL abort_pre_0777: got %h expected %h", disp(),
                         {7'b0000001, 7'b0001111, 7'b0001111, 7'b0001111});
    end
    @(negedge clk);
    X = 14'd5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (disp() !== ALL_BLANK) begin
      errors++; $display("[TB] FAIL abort_disp: got %h expected %h", disp(), ALL_BLANK);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", dones);
    end
    run_conv(14'd42, c);
    checks++;
    if (c !== 16) begin
      errors++; $display("[TB] FAIL abort_fresh_latency: got %0d expected 16", c);
    end
    checks++;
    if (disp() !== {7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010}) begin
      errors++; $display("[TB] FAIL abort_fresh_0042: got %h expected %h", disp(),
                         {7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_busy();
    test_back_to_back();
    test_enable();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
